// File: rtl/contador_param.sv
// contador_param: modulo up/down counter with prescaler tick, load and 7-seg.
// Define CONTADOR_PARAM_SATURATE_EN to hold at the ends instead of wrapping.
module contador_param #(
  parameter int WIDTH  = 4,
  parameter int MODULO = 10,
  parameter int DIV    = 50000000
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc,
  output logic [0:6]       HEX0,
  output logic [0:6]       HEX1
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    P_MAX = PW'(DIV - 1);
  localparam logic [WIDTH-1:0] Q_MAX = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_X = (WIDTH+1)'(MODULO);

  logic [PW-1:0]    p;
  logic             step;
  logic             at_end;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_load;
  logic [7:0]       q8;

  assign tick   = (p == P_MAX);
  assign step   = tick & enable & ~load;
  assign at_end = up_down ? (q == Q_MAX) : (q == '0);
  assign q_load = ({1'b0, load_val} >= MOD_X) ? Q_MAX : load_val;

  always_comb begin
    q_step = q;
    if (at_end) begin
`ifdef CONTADOR_PARAM_SATURATE_EN
      q_step = q;
`else
      q_step = up_down ? '0 : Q_MAX;
`endif
    end else begin
      q_step = up_down ? q + 1'b1 : q - 1'b1;
    end
  end

  // free-running prescaler, independent of enable/load
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      p <= '0;
    end else if (p == P_MAX) begin
      p <= '0;
    end else begin
      p <= p + 1'b1;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      q  <= '0;
      tc <= 1'b0;
    end else if (load) begin
      q  <= q_load;
      tc <= 1'b0;
    end else if (step) begin
      q  <= q_step;
      tc <= at_end;
    end else begin
      tc <= 1'b0;
    end
  end

  function automatic logic [0:6] seg7(input logic [3:0] d);
    logic [0:6] s;
    case (d)
      4'h0:    s = 7'b0000001;
      4'h1:    s = 7'b1001111;
      4'h2:    s = 7'b0010010;
      4'h3:    s = 7'b0000110;
      4'h4:    s = 7'b1001100;
      4'h5:    s = 7'b0100100;
      4'h6:    s = 7'b0100000;
      4'h7:    s = 7'b0001111;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0000100;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b1100000;
      4'hC:    s = 7'b0110001;
      4'hD:    s = 7'b1000010;
      4'hE:    s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

  assign q8   = 8'(q);
  assign HEX0 = seg7(q8[3:0]);
  assign HEX1 = seg7(q8[7:4]);

endmodule

// File: tb/tb_contador_param.sv
// tb_contador_param: directed checks of contador_param (4-bit mod 10, DIV 4)
// plus an 8-bit DIV=1 instance for high-digit decode and wrap.
module tb_contador_param;

`ifdef CONTADOR_PARAM_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic       up_down;
  logic       load;
  logic [3:0] load_val;
  logic [3:0] q;
  logic       tick;
  logic       tc;
  logic [0:6] hex0;
  logic [0:6] hex1;

  logic       en1;
  logic       up1;
  logic       ld1;
  logic [7:0] lv1;
  logic [7:0] q1;
  logic       tick1;
  logic       tc1;
  logic [0:6] h0_1;
  logic [0:6] h1_1;

  int checks = 0;
  int errors = 0;
  logic [3:0] hold_q;

  always #5 clk = ~clk;

  contador_param #(.WIDTH(4), .MODULO(10), .DIV(4)) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .enable  (enable),
    .up_down (up_down),
    .load    (load),
    .load_val(load_val),
    .q       (q),
    .tick    (tick),
    .tc      (tc),
    .HEX0    (hex0),
    .HEX1    (hex1)
  );

  contador_param #(.WIDTH(8), .MODULO(256), .DIV(1)) dut8 (
    .CLOCK_50(clk),
    .reset   (reset),
    .enable  (en1),
    .up_down (up1),
    .load    (ld1),
    .load_val(lv1),
    .q       (q1),
    .tick    (tick1),
    .tc      (tc1),
    .HEX0    (h0_1),
    .HEX1    (h1_1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // wait (bounded) for tick, then take the stepping edge
  task automatic step_chk(input string tag, input int w,
                          input logic [3:0] eq, input logic etc);
    int n = 0;
    while (tick !== 1'b1 && n < 8) begin
      adv(1);
      n++;
    end
    check({tag, "_wait"}, n, w);
    adv(1);
    check({tag, "_q"}, q, eq);
    check({tag, "_tc"}, tc, etc);
  endtask

  initial begin
    reset    = 1'b1;
    enable   = 1'b1;
    up_down  = 1'b1;
    load     = 1'b0;
    load_val = 4'd0;
    en1      = 1'b0;
    up1      = 1'b1;
    ld1      = 1'b0;
    lv1      = 8'd0;
    #3;
    check("rst_q", q, 0);
    check("rst_tc", tc, 0);
    check("rst_tick", tick, 0);
    check("rst_hex0", hex0, 7'b0000001);
    check("rst_hex1", hex1, 7'b0000001);
    check("rst_tick_div1", tick1, 1);
    adv(1);
    reset = 1'b0;

    for (int k = 1; k <= 9; k++) step_chk("up", 3, 4'(k), 1'b0);
    check("hex0_9", hex0, 7'b0000100);
    check("hex1_9", hex1, 7'b0000001);
    step_chk("up_wrap", 3, SAT ? 4'd9 : 4'd0, 1'b1);
    adv(1);
    check("tc_one_cycle", tc, 0);

    up_down  = 1'b0;
    load     = 1'b1;
    load_val = 4'd0;
    adv(1);
    check("ld0_q", q, 0);
    check("ld0_tc", tc, 0);
    load = 1'b0;
    step_chk("dn0", 1, SAT ? 4'd0 : 4'd9, 1'b1);
    adv(1);
    check("dn_tc_clr", tc, 0);
    step_chk("dn1", 2, SAT ? 4'd0 : 4'd8, SAT);
    step_chk("dn2", 3, SAT ? 4'd0 : 4'd7, SAT);

    up_down = 1'b1;
    adv(1);
    load     = 1'b1;
    load_val = 4'd7;
    adv(1);
    check("ld7_q", q, 7);
    check("ld7_tc", tc, 0);
    load_val = 4'd12;
    adv(1);
    check("ld12_clamp", q, 9);
    check("ld12_tick", tick, 1);
    load_val = 4'd3;
    adv(1);
    check("ld3_q", q, 3);
    check("ld3_tc", tc, 0);
    check("ld3_tick", tick, 0);
    load = 1'b0;
    step_chk("ld_phase", 3, 4'd4, 1'b0);

    load     = 1'b1;
    load_val = 4'd8;
    adv(1);
    check("hex0_8", hex0, 7'b0000000);
    load = 1'b0;
    step_chk("s8", 2, 4'd9, 1'b0);
    step_chk("s9", 3, SAT ? 4'd9 : 4'd0, 1'b1);
    step_chk("s10", 3, SAT ? 4'd9 : 4'd1, SAT);

    enable = 1'b0;
    hold_q = SAT ? 4'd9 : 4'd1;
    for (int k = 0; k < 3; k++) step_chk("hold", 3, hold_q, 1'b0);
    load     = 1'b1;
    load_val = 4'd5;
    adv(1);
    check("ld5_q", q, 5);
    load   = 1'b0;
    enable = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("arst_q", q, 0);
    check("arst_hex0", hex0, 7'b0000001);
    check("arst_tc", tc, 0);
    check("arst_tick", tick, 0);
    adv(1);
    reset = 1'b0;
    step_chk("post_rst", 3, 4'd1, 1'b0);

    ld1 = 1'b1;
    lv1 = 8'hAF;
    adv(1);
    check("w8_q", q1, 8'hAF);
    check("w8_hex0_F", h0_1, 7'b0111000);
    check("w8_hex1_A", h1_1, 7'b0001000);
    check("w8_ld_tc", tc1, 0);
    lv1 = 8'hFF;
    adv(1);
    check("w8_q_ff", q1, 8'hFF);
    ld1 = 1'b0;
    en1 = 1'b1;
    adv(1);
    check("w8_wrap_q", q1, SAT ? 8'hFF : 8'h00);
    check("w8_wrap_tc", tc1, 1);
    up1 = 1'b0;
    adv(1);
    check("w8_dn_q", q1, SAT ? 8'hFE : 8'hFF);
    check("w8_dn_tc", tc1, SAT ? 1'b0 : 1'b1);
    en1 = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
